// File: rtl/cntr_pkg.sv
// Shared types and helpers for the I2S RX counters.
package cntr_pkg;

   typedef enum logic {CNT_DOWN = 1'b0, CNT_UP = 1'b1} cnt_dir_t;
   typedef enum logic {CNT_WRAP = 1'b0, CNT_SAT = 1'b1} cnt_mode_t;

   // Widest counter any I2S block feeds into the shared boundary compare.
   localparam int unsigned CNT_MAX_W = 32;

   // Boundary test: up-counting is at or past mod, down-counting is at zero.
   function automatic logic at_boundary(input cnt_dir_t               dir,
                                        input logic [CNT_MAX_W-1:0]   cnt,
                                        input logic [CNT_MAX_W-1:0]   mod);
      logic hit;
      if (dir == CNT_UP) hit = (cnt >= mod);
      else               hit = (cnt == '0);
      return hit;
   endfunction

endpackage

// File: rtl/cntr_presc.sv
// Clock-enable prescaler: emits one tick every presc_i+1 enabled cycles.
module cntr_presc
   import cntr_pkg::*;
#(
   parameter int unsigned PRE_RES = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               en_i,
   input  logic               clr_i,
   input  logic [PRE_RES-1:0] presc_i,
   output logic               tick_o
);

   logic [PRE_RES-1:0] pcnt_q;
   logic [PRE_RES-1:0] pcnt_d;
   logic               period_done;

   // >= rather than == so lowering presc_i mid-period ticks on the next enabled cycle.
   assign period_done = (pcnt_q >= presc_i);
   assign tick_o      = en_i & ~clr_i & period_done;

   // Next prescaler count: clear on load, hold while disabled.
   always_comb begin
      pcnt_d = pcnt_q;
      if (clr_i) begin
         pcnt_d = '0;
      end else if (en_i) begin
         if (period_done) pcnt_d = '0;
         else             pcnt_d = pcnt_q + PRE_RES'(1);
      end
   end

   // Prescaler count register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) pcnt_q <= '0;
      else       pcnt_q <= pcnt_d;
   end

endmodule

// File: rtl/cntr_ext_module.sv
// Programmable-modulo up/down counter with prescaler, load, wrap/saturate and terminal count.
module cntr_ext_module
   import cntr_pkg::*;
#(
   parameter int unsigned CNT_RES = 5,
   parameter int unsigned PRE_RES = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               en_i,
   input  logic [PRE_RES-1:0] presc_i,
   input  logic [CNT_RES-1:0] mod_i,
   input  logic               dir_i,
   input  logic               sat_i,
   input  logic               ld_i,
   input  logic [CNT_RES-1:0] ld_val_i,
   output logic [CNT_RES-1:0] cnt_o,
   output logic               tc_o,
   output logic               sat_o
);

   cnt_dir_t           dir;
   cnt_mode_t          mode;
   logic               tick;
   logic               at_bnd;
   logic [CNT_RES-1:0] cnt_q;
   logic [CNT_RES-1:0] cnt_d;
   logic [CNT_RES-1:0] cnt_tick;
   logic [CNT_RES-1:0] ld_clamp;
   logic               tc_q;
   logic               tc_d;

   assign dir  = cnt_dir_t'(dir_i);
   assign mode = cnt_mode_t'(sat_i);

   // Prescaler restarts its period whenever a load is taken.
   cntr_presc #(
      .PRE_RES (PRE_RES)
   ) u_presc (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (en_i),
      .clr_i   (ld_i),
      .presc_i (presc_i),
      .tick_o  (tick)
   );

   assign at_bnd   = at_boundary(dir, CNT_MAX_W'(cnt_q), CNT_MAX_W'(mod_i));
   assign ld_clamp = (ld_val_i > mod_i) ? mod_i : ld_val_i;

   // Value the counter takes on a tick; up-clamp also covers cnt above a shrunk mod_i.
   always_comb begin
      cnt_tick = cnt_q;
      if (dir == CNT_UP) begin
         if (cnt_q < mod_i)        cnt_tick = cnt_q + CNT_RES'(1);
         else if (mode == CNT_SAT) cnt_tick = mod_i;
         else                      cnt_tick = '0;
      end else begin
         if (cnt_q != '0)          cnt_tick = cnt_q - CNT_RES'(1);
         else if (mode == CNT_SAT) cnt_tick = '0;
         else                      cnt_tick = mod_i;
      end
   end

   // Next state: load beats tick beats hold; tc pulses only on boundary ticks.
   always_comb begin
      cnt_d = cnt_q;
      tc_d  = 1'b0;
      if (ld_i) begin
         cnt_d = ld_clamp;
      end else if (tick) begin
         cnt_d = cnt_tick;
         tc_d  = at_bnd;
      end
   end

   // Counter and terminal-count registers; reset overrides load and tick.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         tc_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tc_q  <= tc_d;
      end
   end

   assign cnt_o = cnt_q;
   assign tc_o  = tc_q;
   assign sat_o = sat_i & at_bnd;

endmodule

// File: tb/tb_cntr_ext_module.sv
// Directed, table-driven bench for cntr_ext_module.
module tb_cntr_ext_module;

   localparam int unsigned CNT_RES = 5;
   localparam int unsigned PRE_RES = 4;

   logic               clk_i = 1'b0;
   logic               rst_i;
   logic               en_i;
   logic [PRE_RES-1:0] presc_i;
   logic [CNT_RES-1:0] mod_i;
   logic               dir_i;
   logic               sat_i;
   logic               ld_i;
   logic [CNT_RES-1:0] ld_val_i;
   logic [CNT_RES-1:0] cnt_o;
   logic               tc_o;
   logic               sat_o;

   always #5 clk_i = ~clk_i;

   cntr_ext_module #(
      .CNT_RES (CNT_RES),
      .PRE_RES (PRE_RES)
   ) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .en_i     (en_i),
      .presc_i  (presc_i),
      .mod_i    (mod_i),
      .dir_i    (dir_i),
      .sat_i    (sat_i),
      .ld_i     (ld_i),
      .ld_val_i (ld_val_i),
      .cnt_o    (cnt_o),
      .tc_o     (tc_o),
      .sat_o    (sat_o)
   );

   typedef struct {
      logic               rst;
      logic               en;
      logic               ld;
      logic [PRE_RES-1:0] presc;
      logic [CNT_RES-1:0] mod;
      logic               dir;
      logic               sat;
      logic [CNT_RES-1:0] ld_val;
      logic [CNT_RES-1:0] e_cnt;
      logic               e_tc;
      logic               e_sat;
   } vec_t;

   vec_t vecs[$];

   // Static configuration picked up by add()/step() for each new vector.
   logic [PRE_RES-1:0] c_presc;
   logic [CNT_RES-1:0] c_mod;
   logic               c_dir;
   logic               c_sat;

   int n_vec = 0;
   int n_err = 0;

   function automatic vec_t mk(input logic rst, input logic en, input logic ld,
                               input logic [CNT_RES-1:0] ldv, input logic [CNT_RES-1:0] ec,
                               input logic et, input logic es);
      vec_t v;
      v.rst = rst;  v.en = en;  v.ld = ld;  v.ld_val = ldv;
      v.presc = c_presc;  v.mod = c_mod;  v.dir = c_dir;  v.sat = c_sat;
      v.e_cnt = ec;  v.e_tc = et;  v.e_sat = es;
      return v;
   endfunction

   function automatic void add(input logic rst, input logic en, input logic ld,
                               input logic [CNT_RES-1:0] ldv, input logic [CNT_RES-1:0] ec,
                               input logic et, input logic es);
      vecs.push_back(mk(rst, en, ld, ldv, ec, et, es));
   endfunction

   // Drive one vector, clock it, and compare outputs 1 time unit after the edge.
   task automatic apply(input vec_t v, input string name);
      rst_i = v.rst;  en_i = v.en;  ld_i = v.ld;  ld_val_i = v.ld_val;
      presc_i = v.presc;  mod_i = v.mod;  dir_i = v.dir;  sat_i = v.sat;
      @(posedge clk_i);
      #1;
      n_vec++;
      if (cnt_o !== v.e_cnt) begin
         n_err++;
         $display("FAIL %s cnt_o got %0d want %0d", name, cnt_o, v.e_cnt);
      end
      if (tc_o !== v.e_tc) begin
         n_err++;
         $display("FAIL %s tc_o got %b want %b", name, tc_o, v.e_tc);
      end
      if (sat_o !== v.e_sat) begin
         n_err++;
         $display("FAIL %s sat_o got %b want %b", name, sat_o, v.e_sat);
      end
   endtask

   task automatic step(input string name, input logic rst, input logic en, input logic ld,
                       input logic [CNT_RES-1:0] ldv, input logic [CNT_RES-1:0] ec,
                       input logic et, input logic es);
      apply(mk(rst, en, ld, ldv, ec, et, es), name);
   endtask

   initial begin
      rst_i = 1'b1;  en_i = 1'b0;  ld_i = 1'b0;  ld_val_i = '0;
      presc_i = '0;  mod_i = '0;  dir_i = 1'b1;  sat_i = 1'b0;

      // Reset and plain binary count over the full 5-bit range.
      c_presc = 4'd0;  c_mod = 5'd31;  c_dir = 1'b1;  c_sat = 1'b0;
      add(1, 0, 0, 0, 5'd0, 0, 0);
      for (int k = 1; k <= 33; k++) add(0, 1, 0, 0, 5'(k % 32), (k == 32), 0);

      // Modulo 10 with divide-by-3 prescaler; one tc at the 10th tick.
      c_presc = 4'd2;  c_mod = 5'd9;
      add(1, 1, 0, 0, 5'd0, 0, 0);
      for (int k = 1; k <= 33; k++) add(0, 1, 0, 0, 5'((k / 3) % 10), (k == 30), 0);
      add(0, 1, 0, 0, 5'd1, 0, 0);
      for (int k = 0; k < 5; k++) add(0, 0, 0, 0, 5'd1, 0, 0);
      add(0, 1, 0, 0, 5'd1, 0, 0);
      add(0, 1, 0, 0, 5'd2, 0, 0);

      // Load then count down into saturation, then reverse.
      c_presc = 4'd0;  c_mod = 5'd9;  c_dir = 1'b0;  c_sat = 1'b1;
      add(0, 1, 1, 5'd3, 5'd3, 0, 0);
      add(0, 1, 0, 0, 5'd2, 0, 0);
      add(0, 1, 0, 0, 5'd1, 0, 0);
      add(0, 1, 0, 0, 5'd0, 0, 1);
      add(0, 1, 0, 0, 5'd0, 1, 1);
      add(0, 1, 0, 0, 5'd0, 1, 1);
      c_dir = 1'b1;
      add(0, 1, 0, 0, 5'd1, 0, 0);

      // Load clamps to mod_i and suppresses the coincident tick.
      c_sat = 1'b0;
      add(0, 1, 1, 5'd20, 5'd9, 0, 0);
      add(0, 1, 0, 0, 5'd0, 1, 0);
      c_sat = 1'b1;
      add(0, 1, 1, 5'd20, 5'd9, 0, 1);
      add(0, 1, 0, 0, 5'd9, 1, 1);

      // Reset discards a tick that would have raised tc.
      c_sat = 1'b0;
      add(0, 1, 1, 5'd9, 5'd9, 0, 0);
      add(1, 1, 1, 5'd4, 5'd0, 0, 0);
      add(0, 1, 0, 0, 5'd1, 0, 0);

      // Shrinking mod_i below the current count.
      c_mod = 5'd20;  c_dir = 1'b1;  c_sat = 1'b0;
      add(0, 1, 1, 5'd12, 5'd12, 0, 0);
      c_mod = 5'd5;
      add(0, 1, 0, 0, 5'd0, 1, 0);
      c_mod = 5'd20;  c_sat = 1'b1;
      add(0, 1, 1, 5'd12, 5'd12, 0, 0);
      c_mod = 5'd5;
      add(0, 1, 0, 0, 5'd5, 1, 1);
      c_mod = 5'd20;  c_sat = 1'b0;  c_dir = 1'b0;
      add(0, 1, 1, 5'd12, 5'd12, 0, 0);
      c_mod = 5'd5;
      add(0, 1, 0, 0, 5'd11, 0, 0);

      // mod_i = 0 pins the counter and tc fires every tick; down-wrap reloads mod_i.
      c_mod = 5'd0;  c_dir = 1'b1;
      add(0, 1, 0, 0, 5'd0, 1, 0);
      add(0, 1, 0, 0, 5'd0, 1, 0);
      c_dir = 1'b0;
      add(0, 1, 0, 0, 5'd0, 1, 0);
      c_mod = 5'd9;
      add(0, 1, 0, 0, 5'd9, 1, 0);
      add(0, 1, 0, 0, 5'd8, 0, 0);

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

      // Reset together with load mid-count; restart honours the full prescaler period.
      c_presc = 4'd2;  c_mod = 5'd9;  c_dir = 1'b1;  c_sat = 1'b0;
      step("rst_ld",   0, 1, 1, 5'd5, 5'd5, 0, 0);
      step("rst_p1",   0, 1, 0, 0,    5'd5, 0, 0);
      step("rst_p2",   0, 1, 0, 0,    5'd5, 0, 0);
      step("rst_six",  0, 1, 0, 0,    5'd6, 0, 0);
      step("rst_hit",  1, 1, 1, 5'd7, 5'd0, 0, 0);
      step("rst_a1",   0, 1, 0, 0,    5'd0, 0, 0);
      step("rst_a2",   0, 1, 0, 0,    5'd0, 0, 0);
      step("rst_a3",   0, 1, 0, 0,    5'd1, 0, 0);

      // Lowering presc_i below the running pcnt ticks on the next enabled cycle.
      c_presc = 4'd7;
      step("pre_rst",  1, 0, 0, 0,    5'd0, 0, 0);
      step("pre_e1",   0, 1, 0, 0,    5'd0, 0, 0);
      step("pre_e2",   0, 1, 0, 0,    5'd0, 0, 0);
      c_presc = 4'd1;
      step("pre_low",  0, 1, 0, 0,    5'd1, 0, 0);
      step("pre_n1",   0, 1, 0, 0,    5'd1, 0, 0);
      step("pre_n2",   0, 1, 0, 0,    5'd2, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
